// File: rtl/z80fi_insn_tracker_if.sv
// Core-side strobes and live registers, plus the retirement packet
// sent to the z80fi_insn_spec_* checkers, grouped as one bundle.
interface z80fi_insn_tracker_if #(
    parameter int MAX_LEN     = 4,
    parameter int ORDER_WIDTH = 32
);
    logic                   insn_start;
    logic                   fetch_valid;
    logic [7:0]             fetch_byte;
    logic                   insn_done;
    logic [15:0]            reg_ip;
    logic [7:0]             reg_a;
    logic [7:0]             reg_f;
    logic [7:0]             reg_r;
    logic                   reg_iff2;

    logic                   z80fi_valid;
    logic [ORDER_WIDTH-1:0] z80fi_order;
    logic [8*MAX_LEN-1:0]   z80fi_insn;
    logic [2:0]             z80fi_insn_len;
    logic [15:0]            z80fi_reg_ip_in;
    logic [7:0]             z80fi_reg_a_in;
    logic [7:0]             z80fi_reg_f_in;
    logic [7:0]             z80fi_reg_r_in;
    logic                   z80fi_reg_iff2_in;
    logic [15:0]            z80fi_reg_ip_out;
    logic [7:0]             z80fi_reg_a_out;
    logic [7:0]             z80fi_reg_f_out;
    logic [7:0]             z80fi_reg_r_out;
    logic                   z80fi_reg_iff2_out;
    logic                   z80fi_error;

    // The core (or a bench standing in for it) drives the strobes and registers
    modport master (
        output insn_start, fetch_valid, fetch_byte, insn_done,
               reg_ip, reg_a, reg_f, reg_r, reg_iff2,
        input  z80fi_valid, z80fi_order, z80fi_insn, z80fi_insn_len,
               z80fi_reg_ip_in, z80fi_reg_a_in, z80fi_reg_f_in,
               z80fi_reg_r_in, z80fi_reg_iff2_in,
               z80fi_reg_ip_out, z80fi_reg_a_out, z80fi_reg_f_out,
               z80fi_reg_r_out, z80fi_reg_iff2_out, z80fi_error
    );

    // The tracker observes the core and produces the packet
    modport slave (
        input  insn_start, fetch_valid, fetch_byte, insn_done,
               reg_ip, reg_a, reg_f, reg_r, reg_iff2,
        output z80fi_valid, z80fi_order, z80fi_insn, z80fi_insn_len,
               z80fi_reg_ip_in, z80fi_reg_a_in, z80fi_reg_f_in,
               z80fi_reg_r_in, z80fi_reg_iff2_in,
               z80fi_reg_ip_out, z80fi_reg_a_out, z80fi_reg_f_out,
               z80fi_reg_r_out, z80fi_reg_iff2_out, z80fi_error
    );
endinterface

// File: rtl/z80fi_insn_tracker.sv
// z80fi instruction tracker: gathers the opcode bytes of each instruction,
// snapshots registers at start and end, and emits one retirement packet
// per instruction, one cycle after insn_done.
module z80fi_insn_tracker #(
    parameter int MAX_LEN     = 4,
    parameter int ORDER_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    z80fi_insn_tracker_if.slave  bus
);
    localparam logic [2:0] MAX_COUNT = 3'(MAX_LEN);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [8*MAX_LEN-1:0]   buf_q, buf_d, retire_buf;
    logic [2:0]             count_q, count_d, retire_len;
    logic                   retire;
    logic                   err_set;
    logic [ORDER_WIDTH-1:0] order_q;

    logic [15:0]            ip_in_q;
    logic [7:0]             a_in_q;
    logic [7:0]             f_in_q;
    logic [7:0]             r_in_q;
    logic                   iff2_in_q;

    // Next-state, byte buffer update and retire/error decisions.
    // A byte fetched together with insn_start is the first byte of the new
    // instruction, so it never lands in a packet that retires that cycle.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        retire     = 1'b0;
        err_set    = 1'b0;
        retire_buf = buf_q;
        retire_len = count_q;

        if (bus.fetch_valid && !bus.insn_start) begin
            if (state_q == IDLE) begin
                err_set = 1'b1;
            end else if (count_q == MAX_COUNT) begin
                err_set = 1'b1;
            end else begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (count_q == 3'(i)) begin
                        buf_d[8*i +: 8] = bus.fetch_byte;
                    end
                end
                count_d = count_q + 3'd1;
            end
        end

        if (bus.insn_done) begin
            if (state_q == COLLECT && count_d != 3'd0) begin
                retire = 1'b1;
            end else begin
                err_set = 1'b1;
            end
            retire_buf = buf_d;
            retire_len = count_d;
            state_d    = IDLE;
        end

        if (bus.insn_start) begin
            if (state_q == COLLECT && !bus.insn_done) begin
                err_set = 1'b1;
            end
            state_d = COLLECT;
            buf_d   = '0;
            count_d = 3'd0;
            if (bus.fetch_valid) begin
                buf_d[7:0] = bus.fetch_byte;
                count_d    = 3'd1;
            end
        end
    end

    // State, buffer, shadow registers, sticky error and the registered packet
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                <= IDLE;
            buf_q                  <= '0;
            count_q                <= 3'd0;
            order_q                <= '0;
            ip_in_q                <= 16'd0;
            a_in_q                 <= 8'd0;
            f_in_q                 <= 8'd0;
            r_in_q                 <= 8'd0;
            iff2_in_q              <= 1'b0;
            bus.z80fi_valid        <= 1'b0;
            bus.z80fi_order        <= '0;
            bus.z80fi_insn         <= '0;
            bus.z80fi_insn_len     <= 3'd0;
            bus.z80fi_reg_ip_in    <= 16'd0;
            bus.z80fi_reg_a_in     <= 8'd0;
            bus.z80fi_reg_f_in     <= 8'd0;
            bus.z80fi_reg_r_in     <= 8'd0;
            bus.z80fi_reg_iff2_in  <= 1'b0;
            bus.z80fi_reg_ip_out   <= 16'd0;
            bus.z80fi_reg_a_out    <= 8'd0;
            bus.z80fi_reg_f_out    <= 8'd0;
            bus.z80fi_reg_r_out    <= 8'd0;
            bus.z80fi_reg_iff2_out <= 1'b0;
            bus.z80fi_error        <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_q           <= buf_d;
            count_q         <= count_d;
            bus.z80fi_valid <= retire;

            if (err_set) begin
                bus.z80fi_error <= 1'b1;
            end

            if (bus.insn_start) begin
                ip_in_q   <= bus.reg_ip;
                a_in_q    <= bus.reg_a;
                f_in_q    <= bus.reg_f;
                r_in_q    <= bus.reg_r;
                iff2_in_q <= bus.reg_iff2;
            end

            if (retire) begin
                order_q                <= order_q + 1'b1;
                bus.z80fi_order        <= order_q;
                bus.z80fi_insn         <= retire_buf;
                bus.z80fi_insn_len     <= retire_len;
                bus.z80fi_reg_ip_in    <= ip_in_q;
                bus.z80fi_reg_a_in     <= a_in_q;
                bus.z80fi_reg_f_in     <= f_in_q;
                bus.z80fi_reg_r_in     <= r_in_q;
                bus.z80fi_reg_iff2_in  <= iff2_in_q;
                bus.z80fi_reg_ip_out   <= bus.reg_ip;
                bus.z80fi_reg_a_out    <= bus.reg_a;
                bus.z80fi_reg_f_out    <= bus.reg_f;
                bus.z80fi_reg_r_out    <= bus.reg_r;
                bus.z80fi_reg_iff2_out <= bus.reg_iff2;
            end
        end
    end
endmodule

// File: tb/tb_z80fi_insn_tracker.sv
// Directed bench for z80fi_insn_tracker with hand-computed packets.
module tb_z80fi_insn_tracker;
    logic clk;
    logic reset;
    int   pass_count;
    int   check_count;
    int   pkt_count;
    int   pkt_mark;

    z80fi_insn_tracker_if #(.MAX_LEN(4), .ORDER_WIDTH(32)) bus ();

    z80fi_insn_tracker #(.MAX_LEN(4), .ORDER_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count valid pulses as seen at each clock edge
    always @(posedge clk) begin
        if (reset) pkt_count = 0;
        else if (bus.z80fi_valid) pkt_count = pkt_count + 1;
    end

    // Drive one cycle of core activity, then settle just after the edge
    task automatic applyStimulus(input logic start, input logic fv,
                                 input logic [7:0] fbyte, input logic done,
                                 input logic [15:0] ip, input logic [7:0] a,
                                 input logic [7:0] f, input logic [7:0] r,
                                 input logic iff2);
        bus.insn_start  = start;
        bus.fetch_valid = fv;
        bus.fetch_byte  = fbyte;
        bus.insn_done   = done;
        bus.reg_ip      = ip;
        bus.reg_a       = a;
        bus.reg_f       = f;
        bus.reg_r       = r;
        bus.reg_iff2    = iff2;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count = check_count + 1;
        if (observed === expected) begin
            pass_count = pass_count + 1;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        pkt_count   = 0;
        reset       = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);
        applyStimulus(0, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;

        checkOutput("rst_valid", 32'(bus.z80fi_valid), 32'd0);
        checkOutput("rst_order", bus.z80fi_order, 32'd0);
        checkOutput("rst_insn", bus.z80fi_insn, 32'd0);
        checkOutput("rst_len", 32'(bus.z80fi_insn_len), 32'd0);
        checkOutput("rst_error", 32'(bus.z80fi_error), 32'd0);

        $display("[TB] ED 5F retire");
        applyStimulus(1, 0, 8'h00, 0, 16'h1000, 8'h00, 8'h44, 8'h85, 1'b1);
        applyStimulus(0, 1, 8'hED, 0, 16'h1001, 8'h00, 8'h44, 8'h86, 1'b1);
        applyStimulus(0, 1, 8'h5F, 0, 16'h1001, 8'h00, 8'h44, 8'h86, 1'b1);
        checkOutput("ld_ar_pre_valid", 32'(bus.z80fi_valid), 32'd0);
        applyStimulus(0, 0, 8'h00, 1, 16'h1002, 8'h85, 8'h84, 8'h87, 1'b1);
        checkOutput("ld_ar_valid", 32'(bus.z80fi_valid), 32'd1);
        checkOutput("ld_ar_insn", bus.z80fi_insn, 32'h00005FED);
        checkOutput("ld_ar_len", 32'(bus.z80fi_insn_len), 32'd2);
        checkOutput("ld_ar_ip_in", 32'(bus.z80fi_reg_ip_in), 32'h1000);
        checkOutput("ld_ar_r_in", 32'(bus.z80fi_reg_r_in), 32'h85);
        checkOutput("ld_ar_f_in", 32'(bus.z80fi_reg_f_in), 32'h44);
        checkOutput("ld_ar_iff2_in", 32'(bus.z80fi_reg_iff2_in), 32'd1);
        checkOutput("ld_ar_ip_out", 32'(bus.z80fi_reg_ip_out), 32'h1002);
        checkOutput("ld_ar_a_out", 32'(bus.z80fi_reg_a_out), 32'h85);
        checkOutput("ld_ar_f_out", 32'(bus.z80fi_reg_f_out), 32'h84);
        checkOutput("ld_ar_r_out", 32'(bus.z80fi_reg_r_out), 32'h87);
        checkOutput("ld_ar_order", bus.z80fi_order, 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 16'h1002, 8'h85, 8'h84, 8'h87, 1'b1);
        checkOutput("ld_ar_pulse_end", 32'(bus.z80fi_valid), 32'd0);
        checkOutput("ld_ar_hold_insn", bus.z80fi_insn, 32'h00005FED);

        $display("[TB] Back-to-back");
        applyStimulus(1, 0, 8'h00, 0, 16'h2000, 8'h00, 8'h00, 8'h10, 1'b0);
        applyStimulus(0, 1, 8'h3E, 0, 16'h2001, 8'h00, 8'h00, 8'h11, 1'b0);
        applyStimulus(0, 1, 8'h12, 0, 16'h2001, 8'h00, 8'h00, 8'h11, 1'b0);
        applyStimulus(1, 0, 8'h00, 1, 16'h2002, 8'h12, 8'h00, 8'h11, 1'b0);
        checkOutput("b2b_a_valid", 32'(bus.z80fi_valid), 32'd1);
        checkOutput("b2b_a_insn", bus.z80fi_insn, 32'h0000123E);
        checkOutput("b2b_a_order", bus.z80fi_order, 32'd1);
        checkOutput("b2b_a_ip_out", 32'(bus.z80fi_reg_ip_out), 32'h2002);
        applyStimulus(0, 1, 8'h00, 0, 16'h2003, 8'h12, 8'h00, 8'h12, 1'b0);
        checkOutput("b2b_gap_valid", 32'(bus.z80fi_valid), 32'd0);
        applyStimulus(0, 0, 8'h00, 1, 16'h2003, 8'h12, 8'h00, 8'h12, 1'b0);
        checkOutput("b2b_b_valid", 32'(bus.z80fi_valid), 32'd1);
        checkOutput("b2b_b_insn", bus.z80fi_insn, 32'h00000000);
        checkOutput("b2b_b_len", 32'(bus.z80fi_insn_len), 32'd1);
        checkOutput("b2b_b_order", bus.z80fi_order, 32'd2);
        checkOutput("b2b_b_ip_in", 32'(bus.z80fi_reg_ip_in), 32'h2002);
        checkOutput("b2b_b_a_in", 32'(bus.z80fi_reg_a_in), 32'h12);
        checkOutput("b2b_error", 32'(bus.z80fi_error), 32'd0);

        $display("[TB] Same-cycle start+fetch and fetch+done");
        applyStimulus(1, 1, 8'hED, 0, 16'h3000, 8'h00, 8'h00, 8'h20, 1'b0);
        applyStimulus(0, 1, 8'h5F, 1, 16'h3002, 8'h20, 8'h00, 8'h22, 1'b0);
        checkOutput("same_valid", 32'(bus.z80fi_valid), 32'd1);
        checkOutput("same_insn", bus.z80fi_insn, 32'h00005FED);
        checkOutput("same_len", 32'(bus.z80fi_insn_len), 32'd2);
        checkOutput("same_order", bus.z80fi_order, 32'd3);
        checkOutput("same_error", 32'(bus.z80fi_error), 32'd0);

        $display("[TB] Overflow");
        applyStimulus(1, 0, 8'h00, 0, 16'h3100, 8'h00, 8'h00, 8'h30, 1'b0);
        applyStimulus(0, 1, 8'hDD, 0, 16'h3100, 8'h00, 8'h00, 8'h30, 1'b0);
        applyStimulus(0, 1, 8'hCB, 0, 16'h3100, 8'h00, 8'h00, 8'h30, 1'b0);
        applyStimulus(0, 1, 8'h05, 0, 16'h3100, 8'h00, 8'h00, 8'h30, 1'b0);
        applyStimulus(0, 1, 8'h46, 0, 16'h3100, 8'h00, 8'h00, 8'h30, 1'b0);
        checkOutput("ovf_pre_error", 32'(bus.z80fi_error), 32'd0);
        applyStimulus(0, 1, 8'h77, 0, 16'h3100, 8'h00, 8'h00, 8'h30, 1'b0);
        applyStimulus(0, 0, 8'h00, 1, 16'h3104, 8'h00, 8'h10, 8'h32, 1'b0);
        checkOutput("ovf_valid", 32'(bus.z80fi_valid), 32'd1);
        checkOutput("ovf_insn", bus.z80fi_insn, 32'h4605CBDD);
        checkOutput("ovf_len", 32'(bus.z80fi_insn_len), 32'd4);
        checkOutput("ovf_error", 32'(bus.z80fi_error), 32'd1);
        checkOutput("ovf_order", bus.z80fi_order, 32'd4);

        reset = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        checkOutput("rst2_error", 32'(bus.z80fi_error), 32'd0);
        checkOutput("rst2_insn", bus.z80fi_insn, 32'd0);

        $display("[TB] Aborted instruction");
        pkt_mark = pkt_count;
        applyStimulus(1, 0, 8'h00, 0, 16'h4000, 8'h00, 8'h00, 8'h40, 1'b0);
        applyStimulus(0, 1, 8'h3E, 0, 16'h4000, 8'h00, 8'h00, 8'h40, 1'b0);
        applyStimulus(1, 0, 8'h00, 0, 16'h4100, 8'h00, 8'h00, 8'h41, 1'b0);
        checkOutput("abort_valid_none", 32'(bus.z80fi_valid), 32'd0);
        applyStimulus(0, 1, 8'h00, 0, 16'h4100, 8'h00, 8'h00, 8'h41, 1'b0);
        checkOutput("abort_error", 32'(bus.z80fi_error), 32'd1);
        applyStimulus(0, 0, 8'h00, 1, 16'h4101, 8'h00, 8'h00, 8'h42, 1'b0);
        checkOutput("abort_valid", 32'(bus.z80fi_valid), 32'd1);
        checkOutput("abort_insn", bus.z80fi_insn, 32'h00000000);
        checkOutput("abort_len", 32'(bus.z80fi_insn_len), 32'd1);
        checkOutput("abort_ip_in", 32'(bus.z80fi_reg_ip_in), 32'h4100);
        checkOutput("abort_order", bus.z80fi_order, 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 16'h4101, 8'h00, 8'h00, 8'h42, 1'b0);
        applyStimulus(0, 0, 8'h00, 0, 16'h4101, 8'h00, 8'h00, 8'h42, 1'b0);
        checkOutput("abort_pkts", 32'(pkt_count - pkt_mark), 32'd1);

        $display("[TB] Reset mid-collect");
        applyStimulus(1, 0, 8'h00, 0, 16'h5000, 8'h00, 8'h00, 8'h50, 1'b0);
        applyStimulus(0, 1, 8'hED, 0, 16'h5000, 8'h00, 8'h00, 8'h50, 1'b0);
        reset = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 16'h5000, 8'h00, 8'h00, 8'h50, 1'b0);
        reset = 1'b0;
        checkOutput("rmc_valid", 32'(bus.z80fi_valid), 32'd0);
        checkOutput("rmc_order", bus.z80fi_order, 32'd0);
        checkOutput("rmc_error_clear", 32'(bus.z80fi_error), 32'd0);
        checkOutput("rmc_len", 32'(bus.z80fi_insn_len), 32'd0);
        pkt_mark = pkt_count;
        applyStimulus(0, 0, 8'h00, 1, 16'h5002, 8'h00, 8'h00, 8'h51, 1'b0);
        checkOutput("rmc_done_valid", 32'(bus.z80fi_valid), 32'd0);
        checkOutput("rmc_done_error", 32'(bus.z80fi_error), 32'd1);
        applyStimulus(0, 0, 8'h00, 0, 16'h5002, 8'h00, 8'h00, 8'h51, 1'b0);
        checkOutput("rmc_pkts", 32'(pkt_count - pkt_mark), 32'd0);

        $display("[TB] Order restarts after reset");
        applyStimulus(1, 1, 8'h00, 0, 16'h6000, 8'h00, 8'h00, 8'h60, 1'b1);
        applyStimulus(0, 0, 8'h00, 1, 16'h6001, 8'h00, 8'h00, 8'h61, 1'b0);
        checkOutput("post_valid", 32'(bus.z80fi_valid), 32'd1);
        checkOutput("post_order", bus.z80fi_order, 32'd0);
        checkOutput("post_ip_in", 32'(bus.z80fi_reg_ip_in), 32'h6000);
        checkOutput("post_iff2_in", 32'(bus.z80fi_reg_iff2_in), 32'd1);
        checkOutput("post_iff2_out", 32'(bus.z80fi_reg_iff2_out), 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 16'h6001, 8'h00, 8'h00, 8'h61, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/z80fi_insn_tracker.md
Name: z80fi_insn_tracker

Overview:
- Upstream producer of the z80fi retirement packet consumed by every z80fi_insn_spec_* checker.
- Collects opcode bytes fetched by the core and snapshots architectural state at instruction start and at instruction end.
- Emits a one-cycle z80fi_valid packet per retired instruction: insn bytes, length, and register in/out values.

Parameters:
- MAX_LEN, 4, maximum instruction bytes captured; insn bus width is 8*MAX_LEN.
- ORDER_WIDTH, 32, width of the retirement sequence counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- insn_start  in  1  pulse: core begins a new instruction (first M1 cycle)
- fetch_valid  in  1  an opcode/operand byte of the current instruction is fetched this cycle
- fetch_byte  in  8  fetched byte
- insn_done  in  1  pulse: current instruction's architectural effects are complete this cycle
- reg_ip  in  16  live IP
- reg_a  in  8  live A
- reg_f  in  8  live F
- reg_r  in  8  live R
- reg_iff2  in  1  live IFF2
- z80fi_valid  out  1  packet valid, one-cycle pulse
- z80fi_order  out  ORDER_WIDTH  retirement index of the packet, starting at 0
- z80fi_insn  out  8*MAX_LEN  instruction bytes; byte n at bits [8n+7:8n]; unused bytes zero
- z80fi_insn_len  out  3  number of bytes captured
- z80fi_reg_ip_in / _a_in / _f_in / _r_in / _iff2_in  out  16/8/8/8/1  values sampled at insn_start
- z80fi_reg_ip_out / _a_out / _f_out / _r_out / _iff2_out  out  16/8/8/8/1  values sampled at insn_done
- z80fi_error  out  1  sticky: protocol violation seen

Behaviour:
- Reset: state IDLE; all outputs 0; byte buffer, length and order counter 0; error cleared.
- States:
  - IDLE: waits for insn_start.
  - COLLECT: accumulates bytes.
- insn_start (from any state):
  - Latch all reg_* into the *_in shadow.
  - Clear buffer and count.
  - Enter COLLECT.
  - If fetch_valid is high in the same cycle, that byte becomes byte 0.
- COLLECT, fetch_valid: store fetch_byte at index count, count += 1.
  - If count == MAX_LEN already: byte dropped, count saturates, error set.
- COLLECT, insn_done:
  - Latch reg_* into the *_out fields.
  - Buffer, including any byte fetched this same cycle, goes to z80fi_insn.
  - Count goes to z80fi_insn_len.
  - *_in shadow goes to *_in outputs.
  - z80fi_valid = 1 on the NEXT cycle (latency 1); order counter increments after emission, wrapping modulo 2^ORDER_WIDTH.
  - Return to IDLE unless insn_start is also asserted.
- insn_done and insn_start in the same cycle:
  - Retire the current instruction as above.
  - Simultaneously begin the next one; new *_in shadow = same-cycle reg_* values (out of old == in of new).
- insn_start while in COLLECT without insn_done: current instruction discarded (no packet), error set, restart.
- insn_done in IDLE, or with count == 0: no packet, error set.
- fetch_valid in IDLE: ignored, error set.
- Packet outputs hold their values after the valid pulse until the next retirement; only z80fi_valid deasserts.
- Reset mid-COLLECT: abandons the instruction, no packet, outputs and order return to 0.

Test Plan:
- ED 5F retire:
  - Stimulus: start with ip=0x1000, r=0x85, iff2=1; fetch ED, 5F; done with a=0x85, ip=0x1002.
  - Required: next cycle valid=1, insn=0x00005FED, len=2, ip_in=0x1000, r_in=0x85, ip_out=0x1002, order=0.
- Back-to-back:
  - Stimulus: done+start in the same cycle, next insn single byte 0x00.
  - Required: two valid pulses; second has insn=0x00000000, len=1, order=1, ip_in equals first's ip_out.
- Overflow:
  - Stimulus: DD CB 05 46 plus a fifth fetch.
  - Required: insn=0x4605CBDD, len=4, error=1.
- Aborted instruction:
  - Stimulus: start, fetch 3E, start again, fetch 00, done.
  - Required: exactly one packet, insn=0x00, len=1, error=1.
- Same-cycle start+fetch and fetch+done:
  - Stimulus: start+fetch ED, then fetch 5F with done in the same cycle.
  - Required: len=2, insn=0x5FED.
- Reset mid-collect:
  - Stimulus: start, fetch ED, assert reset, then done.
  - Required: no valid, order=0, error=1 only from the post-reset done.
